// File: rtl/acc_axil_ctrl_master_pkg.sv
// Shared definitions for the accelerator AXI4-Lite control master: command
// encodings, FSM states, AXI response codes and accelerator register map.
package acc_axil_ctrl_master_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [ADDR_W-1:0] REG_CTRL        = 12'h000;
  localparam logic [ADDR_W-1:0] REG_CFG_CI      = 12'h010;
  localparam logic [ADDR_W-1:0] REG_CFG_CO      = 12'h014;
  localparam logic [ADDR_W-1:0] REG_IFM_SIZE    = 12'h018;
  localparam logic [ADDR_W-1:0] REG_WGT_SIZE    = 12'h01C;
  localparam logic [ADDR_W-1:0] REG_OFM_SIZE    = 12'h020;
  localparam logic [ADDR_W-1:0] REG_TILE_NUM    = 12'h024;
  localparam logic [ADDR_W-1:0] REG_IFM_BASE    = 12'h040;
  localparam logic [ADDR_W-1:0] REG_IFM_BASE_HI = 12'h044;
  localparam logic [ADDR_W-1:0] REG_WGT_BASE    = 12'h048;
  localparam logic [ADDR_W-1:0] REG_WGT_BASE_HI = 12'h04C;
  localparam logic [ADDR_W-1:0] REG_OFM_BASE    = 12'h050;
  localparam logic [ADDR_W-1:0] REG_OFM_BASE_HI = 12'h054;

  function automatic logic poll_match(input logic [DATA_W-1:0] rdata,
                                      input logic [DATA_W-1:0] cmp,
                                      input logic [DATA_W-1:0] mask);
    return (rdata & mask) == (cmp & mask);
  endfunction

endpackage

// File: rtl/acc_axil_ctrl_master.sv
// Single-outstanding AXI4-Lite master that turns write/read/poll commands into
// bus transactions and returns one response per command.
module acc_axil_ctrl_master
  import acc_axil_ctrl_master_pkg::*;
#(
  parameter int POLL_MAX = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, mask_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                is_poll_q;
  logic                aw_done, w_done;
  logic [15:0]         attempts;
  logic                poll_timeout;

  assign AWADDR = addr_q;
  assign WDATA  = wdata_q;
  assign WSTRB  = wstrb_q;
  assign ARADDR = addr_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    AWVALID      = 1'b0;
    WVALID       = 1'b0;
    BREADY       = 1'b0;
    ARVALID      = 1'b0;
    RREADY       = 1'b0;
    rsp_valid    = 1'b0;
    poll_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_op == OP_WRITE) ? ST_WR : ST_RADDR;
      end
      ST_WR: begin
        AWVALID = !aw_done;
        WVALID  = !w_done;
        if ((aw_done || AWREADY) && (w_done || WREADY)) state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = ST_RESP;
      end
      ST_RADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = ST_RDATA;
      end
      ST_RDATA: begin
        RREADY = 1'b1;
        if (RVALID) begin
          state_nxt = ST_RESP;
          // A poll only retries on a clean miss; error responses end it at once.
          if (is_poll_q && RRESP == RESP_OKAY && !poll_match(RDATA, wdata_q, mask_q)) begin
            if (attempts >= POLL_LIMIT) poll_timeout = 1'b1;
            else                        state_nxt = ST_RADDR;
          end
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!ARESETn) begin
      state_nxt = ST_IDLE;
      cmd_ready = 1'b0;
      AWVALID   = 1'b0;
      WVALID    = 1'b0;
      BREADY    = 1'b0;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (cmd_valid && cmd_ready) begin
      addr_q    <= cmd_addr;
      wdata_q   <= cmd_wdata;
      wstrb_q   <= cmd_wstrb;
      mask_q    <= cmd_mask;
      is_poll_q <= (cmd_op == OP_POLL);
    end
  end

  // The attempt count advances per AR handshake, so the first read is attempt 1.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      attempts    <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= RESP_OKAY;
      rsp_timeout <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        attempts    <= '0;
        rsp_rdata   <= '0;
        rsp_resp    <= RESP_OKAY;
        rsp_timeout <= 1'b0;
      end
      if (AWVALID && AWREADY) aw_done <= 1'b1;
      if (WVALID && WREADY)   w_done  <= 1'b1;
      if (BVALID && BREADY)   rsp_resp <= BRESP;
      if (ARVALID && ARREADY) attempts <= attempts + 16'd1;
      if (RVALID && RREADY) begin
        rsp_rdata   <= RDATA;
        rsp_resp    <= RRESP;
        rsp_timeout <= poll_timeout;
      end
    end
  end

endmodule

// File: tb/tb_acc_axil_ctrl_master.sv
// Bench for acc_axil_ctrl_master: two instances (default and POLL_MAX = 4)
// share one AXI4-Lite slave model with configurable ready ordering.
module tb_acc_axil_ctrl_master;
  import acc_axil_ctrl_master_pkg::*;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        ARESETn, sel;
  logic        cmd_valid, rsp_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata, cmd_mask;
  logic [3:0]  cmd_wstrb;

  logic        cmd_ready_a, rsp_valid_a, rsp_timeout_a, awvalid_a, wvalid_a, bready_a, arvalid_a, rready_a;
  logic        cmd_ready_b, rsp_valid_b, rsp_timeout_b, awvalid_b, wvalid_b, bready_b, arvalid_b, rready_b;
  logic [31:0] rsp_rdata_a, wdata_a, rsp_rdata_b, wdata_b;
  logic [1:0]  rsp_resp_a, rsp_resp_b;
  logic [11:0] awaddr_a, araddr_a, awaddr_b, araddr_b;
  logic [3:0]  wstrb_a, wstrb_b;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, s_rresp;
  logic [31:0] s_rdata;

  acc_axil_ctrl_master u_dut_a (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
    .rsp_resp(rsp_resp_a), .rsp_timeout(rsp_timeout_a),
    .AWADDR(awaddr_a), .AWVALID(awvalid_a), .AWREADY(awready),
    .WDATA(wdata_a), .WSTRB(wstrb_a), .WVALID(wvalid_a), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready_a),
    .ARADDR(araddr_a), .ARVALID(arvalid_a), .ARREADY(arready),
    .RDATA(s_rdata), .RRESP(s_rresp), .RVALID(rvalid), .RREADY(rready_a)
  );

  acc_axil_ctrl_master #(.POLL_MAX(4)) u_dut_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
    .rsp_resp(rsp_resp_b), .rsp_timeout(rsp_timeout_b),
    .AWADDR(awaddr_b), .AWVALID(awvalid_b), .AWREADY(awready),
    .WDATA(wdata_b), .WSTRB(wstrb_b), .WVALID(wvalid_b), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready_b),
    .ARADDR(araddr_b), .ARVALID(arvalid_b), .ARREADY(arready),
    .RDATA(s_rdata), .RRESP(s_rresp), .RVALID(rvalid), .RREADY(rready_b)
  );

  // Active-instance view; the unselected instance sits idle.
  logic        cmd_ready, rsp_valid, rsp_timeout, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0] rsp_rdata, m_wdata;
  logic [1:0]  rsp_resp;
  logic [11:0] m_awaddr, m_araddr;
  logic [3:0]  m_wstrb;
  assign cmd_ready   = sel ? cmd_ready_b   : cmd_ready_a;
  assign rsp_valid   = sel ? rsp_valid_b   : rsp_valid_a;
  assign rsp_timeout = sel ? rsp_timeout_b : rsp_timeout_a;
  assign rsp_rdata   = sel ? rsp_rdata_b   : rsp_rdata_a;
  assign rsp_resp    = sel ? rsp_resp_b    : rsp_resp_a;
  assign m_awvalid   = sel ? awvalid_b     : awvalid_a;
  assign m_wvalid    = sel ? wvalid_b      : wvalid_a;
  assign m_bready    = sel ? bready_b      : bready_a;
  assign m_arvalid   = sel ? arvalid_b     : arvalid_a;
  assign m_rready    = sel ? rready_b      : rready_a;
  assign m_wdata     = sel ? wdata_b       : wdata_a;
  assign m_awaddr    = sel ? awaddr_b      : awaddr_a;
  assign m_araddr    = sel ? araddr_b      : araddr_a;
  assign m_wstrb     = sel ? wstrb_b       : wstrb_a;

  // ---------------- slave model ----------------
  int          wr_mode, done_at, poll_base;
  logic [1:0]  rresp_knob;
  logic        b_hold;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got;
  logic [11:0] s_awaddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] mem [0:63];

  // mode 0: both ready; mode 1: W ready only after AW; mode 2: AW ready only after W
  assign awready = (wr_mode != 2) || w_got;
  assign wready  = (wr_mode != 1) || aw_got;
  assign arready = 1'b1;

  logic        aw_hs, w_hs, ar_hs, aw_now, w_now;
  logic [11:0] eff_awaddr;
  logic [31:0] eff_wdata;
  logic [3:0]  eff_wstrb;
  assign aw_hs      = m_awvalid && awready;
  assign w_hs       = m_wvalid && wready;
  assign ar_hs      = m_arvalid && arready;
  assign aw_now     = aw_got || aw_hs;
  assign w_now      = w_got || w_hs;
  assign eff_awaddr = aw_hs ? m_awaddr : s_awaddr;
  assign eff_wdata  = w_hs ? m_wdata : s_wdata;
  assign eff_wstrb  = w_hs ? m_wstrb : s_wstrb;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (aw_hs) begin aw_cnt <= aw_cnt + 1; s_awaddr <= m_awaddr; end
      if (w_hs)  begin w_cnt <= w_cnt + 1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; end
      if (bvalid && m_bready) bvalid <= 1'b0;
      if (aw_now && w_now && !bvalid && !b_hold) begin
        for (int b = 0; b < 4; b++)
          if (eff_wstrb[b]) mem[eff_awaddr[7:2]][8*b +: 8] <= eff_wdata[8*b +: 8];
        bvalid <= 1'b1; bresp <= RESP_OKAY; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
      if (ar_hs) begin
        ar_cnt  <= ar_cnt + 1;
        rvalid  <= 1'b1;
        s_rresp <= rresp_knob;
        if (done_at != 0 && m_araddr == REG_CTRL)
          s_rdata <= (ar_cnt - poll_base + 1 >= done_at) ? 32'h2 : 32'h0;
        else
          s_rdata <= mem[m_araddr[7:2]];
      end else if (rvalid && m_rready) rvalid <= 1'b0;
    end
  end

  int overlap_err = 0;
  always @(negedge ACLK)
    if (ARESETn && (m_awvalid || m_wvalid) && m_arvalid) overlap_err <= overlap_err + 1;

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [31:0] mk);
    @(negedge ACLK);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_mask = mk; cmd_valid = 1'b1;
    for (int t = 0; t < 20 && !cmd_ready; t++) @(negedge ACLK);
    if (!cmd_ready) check("cmd_accept", 64'(cmd_ready), 64'd1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge ACLK); lat++; end
    if (!rsp_valid) check("rsp_wait", 64'(rsp_valid), 64'd1);
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 64'({rsp_valid, cmd_ready}), 64'b01);
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mask;
    int          wr_mode;
    int          done_at;
    logic [1:0]  rresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_to;
    int          exp_lat;
    int          exp_aw, exp_w, exp_ar;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int aw0, w0, ar0, lat;
    sel = v.sel; wr_mode = v.wr_mode; done_at = v.done_at; rresp_knob = v.rresp;
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; poll_base = ar_cnt;
    start_cmd(v.op, v.addr, v.wdata, v.wstrb, v.mask);
    wait_rsp(lat);
    check({tag, "_lat"},     64'(lat),         64'(v.exp_lat));
    check({tag, "_rdata"},   64'(rsp_rdata),   64'(v.exp_rdata));
    check({tag, "_resp"},    64'(rsp_resp),    64'(v.exp_resp));
    check({tag, "_timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
    check({tag, "_hs_cnt"},  64'({16'(aw_cnt - aw0), 16'(w_cnt - w0), 16'(ar_cnt - ar0)}),
                             64'({16'(v.exp_aw), 16'(v.exp_w), 16'(v.exp_ar)}));
    ack_rsp(tag);
  endtask

  vec_t vecs [13];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           sel   op        addr          wdata          strb   mask          mode done rresp        exp_rdata     exp_resp     to   lat aw w ar
    vecs[0]  = '{1'b0, OP_WRITE, REG_CFG_CI,   32'h0000_0010, 4'hF, 32'h0,        1,   0,   RESP_OKAY,   32'h0,        RESP_OKAY,   1'b0, 4, 1, 1, 0};
    vecs[1]  = '{1'b0, OP_READ,  REG_CFG_CI,   32'h0,         4'h0, 32'h0,        0,   0,   RESP_OKAY,   32'h10,       RESP_OKAY,   1'b0, 3, 0, 0, 1};
    vecs[2]  = '{1'b0, OP_WRITE, REG_IFM_BASE, 32'hDEAD_BEEF, 4'hF, 32'h0,        0,   0,   RESP_OKAY,   32'h0,        RESP_OKAY,   1'b0, 3, 1, 1, 0};
    vecs[3]  = '{1'b0, OP_WRITE, REG_IFM_BASE, 32'h1122_3344, 4'h5, 32'h0,        2,   0,   RESP_OKAY,   32'h0,        RESP_OKAY,   1'b0, 4, 1, 1, 0};
    vecs[4]  = '{1'b0, OP_READ,  REG_IFM_BASE, 32'h0,         4'h0, 32'h0,        0,   0,   RESP_OKAY,   32'hDE22_BE44, RESP_OKAY,  1'b0, 3, 0, 0, 1};
    vecs[5]  = '{1'b0, OP_RSVD,  REG_IFM_BASE, 32'h0,         4'h0, 32'h0,        0,   0,   RESP_OKAY,   32'hDE22_BE44, RESP_OKAY,  1'b0, 3, 0, 0, 1};
    vecs[6]  = '{1'b0, OP_POLL,  REG_CTRL,     32'h2,         4'h0, 32'h2,        0,   5,   RESP_OKAY,   32'h2,        RESP_OKAY,   1'b0, 11, 0, 0, 5};
    vecs[7]  = '{1'b0, OP_POLL,  REG_CFG_CI,   32'h1F,        4'h0, 32'hF0,       0,   0,   RESP_OKAY,   32'h10,       RESP_OKAY,   1'b0, 3, 0, 0, 1};
    vecs[8]  = '{1'b0, OP_POLL,  REG_CFG_CI,   32'h55,        4'h0, 32'hFF,       0,   0,   RESP_SLVERR, 32'h10,       RESP_SLVERR, 1'b0, 3, 0, 0, 1};
    vecs[9]  = '{1'b1, OP_POLL,  REG_CTRL,     32'h2,         4'h0, 32'h2,        0,   0,   RESP_OKAY,   32'h0,        RESP_OKAY,   1'b1, 9, 0, 0, 4};
    vecs[10] = '{1'b1, OP_WRITE, REG_CFG_CO,   32'h20,        4'hF, 32'h0,        0,   0,   RESP_OKAY,   32'h0,        RESP_OKAY,   1'b0, 3, 1, 1, 0};
    vecs[11] = '{1'b1, OP_POLL,  REG_CTRL,     32'h2,         4'h0, 32'h2,        0,   4,   RESP_OKAY,   32'h2,        RESP_OKAY,   1'b0, 9, 0, 0, 4};
    vecs[12] = '{1'b1, OP_READ,  REG_CFG_CO,   32'h0,         4'h0, 32'h0,        0,   0,   RESP_OKAY,   32'h20,       RESP_OKAY,   1'b0, 3, 0, 0, 1};

    ARESETn = 1'b0; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; cmd_mask = '0;
    wr_mode = 0; done_at = 0; poll_base = 0; rresp_knob = RESP_OKAY; b_hold = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_handshakes", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_timeout}), 64'd0);
    check("rst_rsp_regs", 64'({rsp_rdata, rsp_resp}), 64'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Response held off for 10 cycles while another command waits.
    begin
      int lat, aw0;
      sel = 1'b0; wr_mode = 0; done_at = 0; rresp_knob = RESP_OKAY;
      start_cmd(OP_READ, REG_IFM_BASE, 32'h0, 4'h0, 32'h0);
      wait_rsp(lat);
      aw0 = aw_cnt;
      cmd_op = OP_WRITE; cmd_addr = REG_TILE_NUM; cmd_wdata = 32'h7; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        check($sformatf("hold_stable_%0d", k),
              64'({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready}),
              64'({1'b1, 32'hDE22_BE44, 2'b00, 1'b0, 1'b0}));
        @(negedge ACLK);
      end
      cmd_valid = 1'b0;
      ack_rsp("hold");
      check("hold_no_write", 64'(aw_cnt - aw0), 64'd0);
    end

    // Reset asserted while waiting in WRESP.
    begin
      sel = 1'b0; wr_mode = 0; b_hold = 1'b1;
      start_cmd(OP_WRITE, REG_OFM_SIZE, 32'h99, 4'hF, 32'h0);
      @(negedge ACLK);
      check("wresp_bready", 64'({m_bready, rsp_valid}), 64'b10);
      ARESETn = 1'b0;
      @(negedge ACLK);
      check("mid_rst_outputs",
            64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, cmd_ready}), 64'd0);
      ARESETn = 1'b1; b_hold = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge ACLK);
        check($sformatf("post_rst_idle_%0d", k),
              64'({rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, cmd_ready}), 64'b0000001);
      end
      run_vec('{1'b0, OP_READ, REG_OFM_SIZE, 32'h0, 4'h0, 32'h0, 0, 0, RESP_OKAY,
                32'h0, RESP_OKAY, 1'b0, 3, 0, 0, 1}, "after_rst");
    end

    check("no_aw_ar_overlap", 64'(overlap_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_axil_ctrl_master.md
ACC_AXIL_CTRL_MASTER -- requirements
Module: acc_axil_ctrl_master

Interface
REQ-001 Parameter POLL_MAX, default 1024: maximum read attempts per poll command; legal range 1..65535.
REQ-002 ACLK  in  1  clock; all logic rising-edge.
REQ-003 ARESETn  in  1  reset, synchronous, active-low; clock ACLK.
REQ-004 cmd_valid  in  1 / cmd_ready  out  1  command handshake.
REQ-005 cmd_op  in  2  00 = write, 01 = read, 10 = poll, 11 = reserved (treated as read).
REQ-006 cmd_addr  in  12 / cmd_wdata  in  32 / cmd_wstrb  in  4  target address, write data or poll compare value, byte strobes.
REQ-007 cmd_mask  in  32  poll compare mask.
REQ-008 rsp_valid  out  1 / rsp_ready  in  1  response handshake.
REQ-009 rsp_rdata  out  32 / rsp_resp  out  2 / rsp_timeout  out  1  last read data, last BRESP/RRESP, poll expiry flag.
REQ-010 AXI4-Lite master ports: AWADDR out 12, AWVALID out 1, AWREADY in 1, WDATA out 32, WSTRB out 4, WVALID out 1, WREADY in 1, BRESP in 2, BVALID in 1, BREADY out 1, ARADDR out 12, ARVALID out 1, ARREADY in 1, RDATA in 32, RRESP in 2, RVALID in 1, RREADY out 1.

Function
REQ-011 FSM states: IDLE, WR, WRESP, RADDR, RDATA, RESP.
REQ-012 cmd_ready = 1 only in IDLE; a command is captured into internal registers on cmd_valid & cmd_ready.
REQ-013 IDLE -> WR on a write command; IDLE -> RADDR on a read or poll command.
REQ-014 WR: AWVALID and WVALID both assert in the first WR cycle; each deasserts independently on its own handshake; exit to WRESP when both handshakes are done.
REQ-015 The write channel shall tolerate AWREADY and WREADY arriving in any order, in the same cycle, or with W accepted only after AW; AWADDR, WDATA and WSTRB stay stable while their VALID is high.
REQ-016 WRESP: BREADY = 1; on BVALID, capture BRESP into rsp_resp, then go to RESP.
REQ-017 RADDR: ARVALID = 1 with a stable ARADDR; on ARREADY go to RDATA.
REQ-018 RDATA: RREADY = 1; on RVALID, capture RDATA into rsp_rdata and RRESP into rsp_resp.
REQ-019 Read command: RDATA -> RESP after the capture.
REQ-020 Poll match condition: (RDATA & cmd_mask) == (cmd_wdata & cmd_mask).
REQ-021 Poll: on match -> RESP with rsp_timeout = 0.
REQ-022 Poll: on no match with attempt count < POLL_MAX -> RADDR (re-issue the read) and increment the 16-bit attempt counter.
REQ-023 Poll: on no match with attempt count == POLL_MAX -> RESP with rsp_timeout = 1.
REQ-024 Poll: an RRESP other than OKAY ends the poll immediately (-> RESP, rsp_timeout = 0, rsp_resp = RRESP).
REQ-025 The attempt counter clears on command capture; the first read counts as attempt 1.
REQ-026 RESP: rsp_valid = 1 and rsp_* stay stable until rsp_ready; RESP -> IDLE on the handshake.
REQ-027 For write commands rsp_rdata is 0 and rsp_timeout is 0.
REQ-028 Back-to-back commands: minimum one IDLE cycle between the response handshake and the next cmd_ready.
REQ-029 Latency against a zero-wait slave: write command accept to rsp_valid = 3 cycles; read command accept to rsp_valid = 3 cycles.
REQ-030 At most one outstanding AXI transaction at any time; AW/W and AR are never active together.

Reset
REQ-031 While ARESETn = 0: FSM -> IDLE.
REQ-032 While ARESETn = 0: AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout = 0.
REQ-033 While ARESETn = 0: rsp_rdata = 0, rsp_resp = 0, attempt counter = 0.
REQ-034 While ARESETn = 0: cmd_ready = 0; cmd_ready = 1 in the first cycle after reset deassertion.
REQ-035 Reset mid-transaction abandons the transaction: no response is generated and the captured command is discarded.

Structure
REQ-036 The shared package holds: cmd_op encodings, FSM state encoding, AXI response codes (OKAY = 00, SLVERR = 10), and accelerator register offsets (CTRL 0x000, CFG_CI 0x010, CFG_CO 0x014, IFM_SIZE 0x018, WGT_SIZE 0x01C, OFM_SIZE 0x020, TILE_NUM 0x024, IFM/WGT/OFM base 0x040/0x048/0x050, upper words at +4).
REQ-037 The block is a single module with no sub-modules.

Verification
REQ-038 Write 0x0000_0010 to CFG_CI with wstrb 0xF, slave asserting WREADY one cycle after AWREADY -> a single AW and a single W handshake, rsp_resp = 00, and a readback returns 0x10.
REQ-039 Write to 0x040 with AWREADY and WREADY high in the same cycle -> both handshakes complete in one cycle and rsp_valid follows 2 cycles later.
REQ-040 Poll CTRL with mask 0x2 and value 0x2, ap_done rising on the 5th read -> exactly 5 AR handshakes, rsp_rdata[1] = 1, rsp_timeout = 0.
REQ-041 Poll with POLL_MAX = 4 and the condition never met -> 4 reads, then rsp_timeout = 1.
REQ-042 Hold rsp_ready low for 10 cycles -> rsp_* remain stable and cmd_ready stays 0 throughout.
REQ-043 Assert ARESETn = 0 while in WRESP -> all VALID/READY outputs are 0 in the next cycle and no rsp_valid is produced after reset is released.
